sumres_seq: RTL and testbench

- Sequencing stage wrapped around the 3-operand add/subtract datapath.
- Accepts operands A, B, C one at a time over a valid/ready stream and registers them to drive the combinational adder inputs.
- Waits a fixed settle time, captures the adder's sum and carry flags, and presents them downstream over a valid/ready handshake.
- Turns the purely combinational adder into a flow-controlled, one-result-at-a-time unit.

---
 rtl/sumres_pkg.sv | 10 +
 rtl/sumres_seq.sv | 97 +++++++++
 tb/tb_sumres_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sumres_pkg.sv
// sumres_pkg: shared types and constants for the sumres sequencing stage
package sumres_pkg;
  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_C, WAIT, OUT} state_t;
  localparam int W_DEF = 4;
  localparam int COUT0 = 0;
  localparam int COUT1 = 1;
  localparam int CFOUT0 = 2;
  localparam int CFOUT1 = 3;
  localparam int CNT_W = 4;
endpackage

// File: rtl/sumres_seq.sv
// sumres_seq: loads A/B/C over a valid/ready stream, lets the adder settle, then
// presents the captured sum and carries downstream over a valid/ready handshake
module sumres_seq
  import sumres_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sub,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] c_o,
  output logic         sub_o,
  input  logic [W+1:0] s_i,
  input  logic [1:0]   cout_i,
  input  logic [1:0]   cfout_i,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W+1:0] res_data,
  output logic [3:0]   res_flags,
  output logic         res_sub,
  output logic [7:0]   res_cnt
);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0] a_q, b_q, c_q;
  logic sub_q, res_sub_q;
  logic [W+1:0] res_data_q;
  logic [3:0] res_flags_q;
  logic [7:0] res_cnt_q;
  logic take;
  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
  assign res_valid = state_q == OUT;
  assign take = in_valid && in_ready;
  assign a_o = a_q;
  assign b_o = b_q;
  assign c_o = c_q;
  assign sub_o = sub_q;
  assign res_data = res_data_q;
  assign res_flags = res_flags_q;
  assign res_sub = res_sub_q;
  assign res_cnt = res_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      sub_q <= 1'b0;
      res_data_q <= '0;
      res_flags_q <= '0;
      res_sub_q <= 1'b0;
      res_cnt_q <= '0;
    end else if (clr) begin
      state_q <= LOAD_A;
      cnt_q <= '0;
    end else begin
      case (state_q)
        LOAD_A: if (take) begin
          a_q <= in_data;
          sub_q <= in_sub;
          state_q <= LOAD_B;
        end
        LOAD_B: if (take) begin
          b_q <= in_data;
          state_q <= LOAD_C;
        end
        LOAD_C: if (take) begin
          c_q <= in_data;
          cnt_q <= CNT_W'(SETTLE);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 1) begin
            res_data_q <= s_i;
            res_flags_q <= {cfout_i, cout_i};
            res_sub_q <= sub_q;
            state_q <= OUT;
          end
        end
        OUT: if (res_ready) begin
          res_cnt_q <= res_cnt_q + 1'b1;
          state_q <= LOAD_A;
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_sumres_seq.sv
// tb_sumres_seq: directed checks of the sumres stage against a behavioural adder
module tb_sumres_seq;
  localparam int W = 4;
  logic clk = 0, rst = 0, clr = 0, in_valid = 0, in_sub = 0, res_ready = 0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] a1, b1, c1, a3, b3, c3;
  logic sub1, sub3, rdy1, rdy3, rv1, rv3, rs1, rs3;
  logic [W+1:0] rd1, rd3;
  logic [3:0] rf1, rf3;
  logic [7:0] rc1, rc3;
  logic [W+5:0] ad1, ad3;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [W+5:0] adder(input logic [W-1:0] a, b, c, input logic sub);
    logic [W+1:0] s;
    s = sub ? {2'b0, a} - {2'b0, b} - {2'b0, c} : {2'b0, a} + {2'b0, b} + {2'b0, c};
    return {s[0], sub, s[W+1:W], s};
  endfunction

  assign ad1 = adder(a1, b1, c1, sub1);
  assign ad3 = adder(a3, b3, c3, sub3);

  sumres_seq #(.W(W), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_sub(in_sub), .a_o(a1), .b_o(b1), .c_o(c1), .sub_o(sub1),
    .s_i(ad1[W+1:0]), .cout_i(ad1[W+3:W+2]), .cfout_i(ad1[W+5:W+4]),
    .res_valid(rv1), .res_ready(res_ready), .res_data(rd1), .res_flags(rf1),
    .res_sub(rs1), .res_cnt(rc1));

  sumres_seq #(.W(W), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .in_sub(in_sub), .a_o(a3), .b_o(b3), .c_o(c3), .sub_o(sub3),
    .s_i(ad3[W+1:0]), .cout_i(ad3[W+3:W+2]), .cfout_i(ad3[W+5:W+4]),
    .res_valid(rv3), .res_ready(res_ready), .res_data(rd3), .res_flags(rf3),
    .res_sub(rs3), .res_cnt(rc3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic s);
    in_valid = 1;
    in_data = d;
    in_sub = s;
    step();
    in_valid = 0;
  endtask

  task automatic pulse_rst();
    #2 rst = 1;
    #2 rst = 0;
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    #12 rst = 0;
    step();
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b exp 1", rdy1); end
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL reset_res_valid got %0b exp 0", rv1); end
    checks++; if ({rd1, rf1, rs1, rc1, a1, b1, c1, sub1} !== '0) begin failures++; $display("FAIL reset_regs got %0h exp 0", {rd1, rf1, rs1, rc1, a1, b1, c1, sub1}); end
  endtask

  task automatic test_add();
    beat(5, 0); beat(6, 0); beat(7, 0);
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL add_wait_valid got %0b exp 0", rv1); end
    step();
    checks++; if (rv1 !== 1'b1) begin failures++; $display("FAIL add_valid got %0b exp 1", rv1); end
    checks++; if (rd1 !== 6'd18) begin failures++; $display("FAIL add_data got %0d exp 18", rd1); end
    checks++; if (rf1 !== 4'b0001) begin failures++; $display("FAIL add_flags got %b exp 0001", rf1); end
    checks++; if (rs1 !== 1'b0) begin failures++; $display("FAIL add_sub got %0b exp 0", rs1); end
    res_ready = 1;
    step();
    res_ready = 0;
    checks++; if (rc1 !== 8'd1) begin failures++; $display("FAIL add_cnt got %0d exp 1", rc1); end
    checks++; if (rv1 !== 1'b0 || rdy1 !== 1'b1) begin failures++; $display("FAIL add_release got valid=%0b ready=%0b exp 0/1", rv1, rdy1); end
  endtask

  task automatic test_sub();
    beat(9, 1); beat(3, 0); beat(2, 0);
    checks++; if (sub1 !== 1'b1) begin failures++; $display("FAIL sub_sub_o got %0b exp 1", sub1); end
    step();
    checks++; if (rd1 !== 6'd4) begin failures++; $display("FAIL sub_data got %0d exp 4", rd1); end
    checks++; if (rf1 !== 4'b0100) begin failures++; $display("FAIL sub_flags got %b exp 0100", rf1); end
    checks++; if (rs1 !== 1'b1) begin failures++; $display("FAIL sub_res_sub got %0b exp 1", rs1); end
    res_ready = 1;
    step();
    res_ready = 0;
    checks++; if (rc1 !== 8'd2) begin failures++; $display("FAIL sub_cnt got %0d exp 2", rc1); end
  endtask

  task automatic test_backpressure();
    beat(1, 0); beat(2, 0); beat(3, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data = 15;
      step();
      checks++; if (rv1 !== 1'b1 || rd1 !== 6'd6 || rdy1 !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got valid=%0b data=%0d ready=%0b exp 1/6/0", i, rv1, rd1, rdy1); end
    end
    in_valid = 0;
    checks++; if (a1 !== 4'd1) begin failures++; $display("FAIL bp_a_unsampled got %0d exp 1", a1); end
    res_ready = 1;
    step();
    res_ready = 0;
    checks++; if (rdy1 !== 1'b1 || rc1 !== 8'd3) begin failures++; $display("FAIL bp_release got ready=%0b cnt=%0d exp 1/3", rdy1, rc1); end
  endtask

  task automatic test_rst_mid();
    beat(4, 1); beat(5, 0);
    #2 rst = 1;
    #1;
    checks++; if ({a1, b1, sub1, rc1, rd1} !== '0 || rdy1 !== 1'b1) begin failures++; $display("FAIL rst_async got regs=%0h ready=%0b exp 0/1", {a1, b1, sub1, rc1, rd1}, rdy1); end
    #1 rst = 0;
    step();
    beat(7, 0); beat(1, 0); beat(1, 0);
    step();
    checks++; if (rv1 !== 1'b1 || rd1 !== 6'd9) begin failures++; $display("FAIL rst_fresh got valid=%0b data=%0d exp 1/9", rv1, rd1); end
    res_ready = 1;
    step();
    res_ready = 0;
    checks++; if (rc1 !== 8'd1) begin failures++; $display("FAIL rst_cnt got %0d exp 1", rc1); end
  endtask

  task automatic test_clr();
    pulse_rst();
    beat(3, 0); beat(4, 0); beat(5, 0);
    step();
    clr = 1;
    step();
    clr = 0;
    checks++; if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin failures++; $display("FAIL clr_wait got ready=%0b valid=%0b exp 1/0", rdy3, rv3); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (rv3 !== 1'b0 || rd3 !== 6'd0 || rc3 !== 8'd0) begin failures++; $display("FAIL clr_noresult got valid=%0b data=%0d cnt=%0d exp 0/0/0", rv3, rd3, rc3); end
    beat(2, 0); beat(2, 0); beat(2, 0);
    step(); step(); step();
    checks++; if (rv3 !== 1'b1 || rd3 !== 6'd6) begin failures++; $display("FAIL clr_s3_result got valid=%0b data=%0d exp 1/6", rv3, rd3); end
    clr = 1;
    res_ready = 1;
    step();
    clr = 0;
    res_ready = 0;
    checks++; if (rv3 !== 1'b0 || rdy3 !== 1'b1 || rc3 !== 8'd0) begin failures++; $display("FAIL clr_out got valid=%0b ready=%0b cnt=%0d exp 0/1/0", rv3, rdy3, rc3); end
    checks++; if (rc1 !== 8'd0 || rd3 !== 6'd6) begin failures++; $display("FAIL clr_hold got cnt1=%0d data3=%0d exp 0/6", rc1, rd3); end
  endtask

  task automatic test_back_to_back();
    pulse_rst();
    in_valid = 1;
    in_data = 1;
    in_sub = 0;
    res_ready = 1;
    for (int i = 1; i <= 1280; i++) begin
      step();
      checks++; if (rv1 !== (i % 5 == 4) || rc1 !== 8'((i / 5) % 256)) begin failures++; $display("FAIL b2b_cycle%0d got valid=%0b cnt=%0d exp %0b/%0d", i, rv1, rc1, i % 5 == 4, (i / 5) % 256); end
    end
    in_valid = 0;
    res_ready = 0;
    checks++; if (rc1 !== 8'd0) begin failures++; $display("FAIL b2b_wrap got %0d exp 0", rc1); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_rst_mid();
    test_clr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
